// File: rtl/sevseg_bus_if.sv
// Register bus between the CPU side and the seven-segment scan controller.
interface sevseg_bus_if;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, output we, output addr, output wdata, input rdata);
  modport slave  (input sel, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/sevseg_scan_ctrl.sv
// Memory-mapped 8-digit multiplexed seven-segment scan controller.
// Registers: 0 DATA (shadowed, copied to the display at frame boundaries),
// 1 CTRL, 2 STATUS (read-only), 3 reserved.
// Optional build macro SEVSEG_BLINK_EN adds a per-digit blink mask in CTRL[23:16].
module sevseg_scan_ctrl #(
  parameter int unsigned PHASE_CYCLES = 625,
  parameter int unsigned BLINK_SHIFT  = 7
) (
  input  logic             clk,
  input  logic             rst,
  sevseg_bus_if.slave      bus,
  output logic [7:0]       an,
  output logic [6:0]       a_to_g
);

  localparam int unsigned CNT_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);

  // Blink gating selects one bit of the 8-bit frame counter.
  if (BLINK_SHIFT > 7) begin : g_blink_shift_chk
    $error("BLINK_SHIFT must select a bit of the 8-bit frame counter");
  end

  // Register state
  logic [31:0]      shadow_q, shadow_d;
  logic [31:0]      active_q, active_d;
  logic             pending_q, pending_d;
  logic [7:0]       frame_q, frame_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       phase_q, phase_d;
  logic [2:0]       idx_q, idx_d;
  logic             en_q, lzb_q;
  logic [3:0]       bright_q;
  logic [7:0]       mask_q;
`ifdef SEVSEG_BLINK_EN
  logic [7:0]       blink_q;
`endif
  logic [31:0]      rdata_q, rdata_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic        wr_c, rd_c, wr_data_c, wr_ctrl_c;
  logic        cnt_wrap_c, phase_wrap_c, frame_wrap_c;
  logic [31:0] ctrl_rd_c;
  logic [7:0]  zero_from_c;
  logic [3:0]  nib_c;
  logic        blink_c, lit_c;

  assign wr_c         = bus.sel & bus.we;
  assign rd_c         = bus.sel & ~bus.we;
  assign wr_data_c    = wr_c & (bus.addr == 2'd0);
  assign wr_ctrl_c    = wr_c & (bus.addr == 2'd1);
  assign cnt_wrap_c   = (cnt_q == CNT_LAST);
  assign phase_wrap_c = cnt_wrap_c & (phase_q == 4'd15);
  assign frame_wrap_c = en_q & phase_wrap_c & (idx_q == 3'd7);

  // Active-low segment decode, bit6 = a ... bit0 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0:    hex_to_seg = 7'b0000001;
      4'h1:    hex_to_seg = 7'b1001111;
      4'h2:    hex_to_seg = 7'b0010010;
      4'h3:    hex_to_seg = 7'b0000110;
      4'h4:    hex_to_seg = 7'b1001100;
      4'h5:    hex_to_seg = 7'b0100100;
      4'h6:    hex_to_seg = 7'b0100000;
      4'h7:    hex_to_seg = 7'b0001111;
      4'h8:    hex_to_seg = 7'b0000000;
      4'h9:    hex_to_seg = 7'b0000100;
      4'hA:    hex_to_seg = 7'b0001000;
      4'hB:    hex_to_seg = 7'b1100000;
      4'hC:    hex_to_seg = 7'b0110001;
      4'hD:    hex_to_seg = 7'b1000010;
      4'hE:    hex_to_seg = 7'b0110000;
      default: hex_to_seg = 7'b0111000;
    endcase
  endfunction

  // Scan counters, shadow/active transfer and pending flag next state.
  always_comb begin
    shadow_d  = wr_data_c ? bus.wdata : shadow_q;
    active_d  = active_q;
    pending_d = pending_q | wr_data_c;
    frame_d   = frame_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    if (!en_q) begin
      // Disabled: display tracks the shadow directly and scan is parked at 0.
      active_d  = shadow_d;
      pending_d = 1'b0;
      cnt_d     = '0;
      phase_d   = '0;
      idx_d     = '0;
    end else begin
      cnt_d = cnt_wrap_c ? '0 : cnt_q + 1'b1;
      if (cnt_wrap_c)   phase_d = phase_q + 4'd1;
      if (phase_wrap_c) idx_d   = idx_q + 3'd1;
      if (frame_wrap_c) begin
        // Same-cycle DATA write is forwarded through shadow_d.
        active_d  = shadow_d;
        pending_d = 1'b0;
        frame_d   = frame_q + 8'd1;
      end
    end
  end

  // CTRL readback image.
  always_comb begin
    ctrl_rd_c = {16'h0, mask_q, bright_q, 2'b00, lzb_q, en_q};
`ifdef SEVSEG_BLINK_EN
    ctrl_rd_c[23:16] = blink_q;
`endif
  end

  // Register read mux; rdata holds when no read is issued.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_c) begin
      case (bus.addr)
        2'd0:    rdata_d = shadow_q;
        2'd1:    rdata_d = ctrl_rd_c;
        2'd2:    rdata_d = {16'h0, frame_q, 4'h0, pending_q, idx_q};
        default: rdata_d = 32'h0;
      endcase
    end
  end

  // zero_from_c[i]: nibbles i..7 of the active value are all zero.
  always_comb begin
    zero_from_c = '0;
    for (int i = 0; i < 8; i++) begin
      zero_from_c[i] = ((active_q >> (4 * i)) == 32'h0);
    end
  end

  // Anode/segment next values for the current slot position.
  always_comb begin
    nib_c = active_q[{idx_q, 2'b00} +: 4];
`ifdef SEVSEG_BLINK_EN
    blink_c = blink_q[idx_q] & frame_q[BLINK_SHIFT[2:0]];
`else
    blink_c = 1'b0;
`endif
    lit_c = en_q & mask_q[idx_q]
          & ~(lzb_q & (idx_q != 3'd0) & zero_from_c[idx_q])
          & ~blink_c
          & (phase_q <= bright_q)
          & ~((phase_q == 4'd0) & (cnt_q == '0));
    an_d = 8'hFF;
    if (lit_c) an_d[idx_q] = 1'b0;
    seg_d = lit_c ? hex_to_seg(nib_c) : 7'h7F;
  end

  // Datapath, scan and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      frame_q   <= '0;
      cnt_q     <= '0;
      phase_q   <= '0;
      idx_q     <= '0;
      rdata_q   <= '0;
      an_q      <= 8'hFF;
      seg_q     <= 7'h7F;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      frame_q   <= frame_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      rdata_q   <= rdata_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  // CTRL register; new settings apply from the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= 1'b1;
      lzb_q    <= 1'b0;
      bright_q <= 4'hF;
      mask_q   <= 8'hFF;
`ifdef SEVSEG_BLINK_EN
      blink_q  <= '0;
`endif
    end else if (wr_ctrl_c) begin
      en_q     <= bus.wdata[0];
      lzb_q    <= bus.wdata[1];
      bright_q <= bus.wdata[7:4];
      mask_q   <= bus.wdata[15:8];
`ifdef SEVSEG_BLINK_EN
      blink_q  <= bus.wdata[23:16];
`endif
    end
  end

  assign bus.rdata = rdata_q;
  assign an        = an_q;
  assign a_to_g    = seg_q;

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Self-checking bench for sevseg_scan_ctrl: register vector table, directed
// display sequences and randomized bus traffic against a reference model
// that derives scan position from a linear frame-relative tick count.
module tb_sevseg_scan_ctrl;

  localparam int unsigned PC    = 2;
  localparam int unsigned BS    = 7;
  localparam int          SLOT  = 16 * PC;
  localparam int          FRAME = 8 * SLOT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] an;
  logic [6:0] a_to_g;

  sevseg_bus_if bus ();

  sevseg_scan_ctrl #(.PHASE_CYCLES(PC), .BLINK_SHIFT(BS)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .an     (an),
    .a_to_g (a_to_g)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                               7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  // Reference model state
  logic [31:0] m_shadow, m_active, m_rdata;
  logic        m_pending, m_en, m_lzb;
  logic [3:0]  m_bright;
  logic [7:0]  m_mask, m_blink, m_frame, m_an;
  logic [6:0]  m_seg;
  int          m_tick;

  // Per-frame tallies of what the DUT displayed
  int         cnt_low [8];
  logic [6:0] seg_seen [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ctrl_word();
    logic [31:0] w;
    w = {16'h0, m_mask, m_bright, 2'b00, m_lzb, m_en};
`ifdef SEVSEG_BLINK_EN
    w[23:16] = m_blink;
`endif
    return w;
  endfunction

  // Advance the model across one clock edge using the inputs present at it.
  task automatic model_step();
    int   idx, phase;
    bit   lit, was_en;
    logic [3:0] nib;
    if (rst) begin
      m_shadow = '0; m_active = '0; m_pending = 1'b0; m_frame = '0; m_tick = 0;
      m_en = 1'b1; m_lzb = 1'b0; m_bright = 4'hF; m_mask = 8'hFF; m_blink = '0;
      m_rdata = '0; m_an = 8'hFF; m_seg = 7'h7F;
      return;
    end
    idx   = (m_tick / SLOT) % 8;
    phase = (m_tick / PC) % 16;
    lit   = m_en && m_mask[idx] && (phase <= int'(m_bright)) && ((m_tick % SLOT) != 0);
    if (m_lzb && idx > 0 && (m_active >> (4 * idx)) == 32'h0) lit = 1'b0;
`ifdef SEVSEG_BLINK_EN
    if (m_blink[idx] && m_frame[BS]) lit = 1'b0;
`endif
    nib   = 4'(m_active >> (4 * idx));
    m_an  = lit ? ~(8'(1) << idx) : 8'hFF;
    m_seg = lit ? seg_tab[nib] : 7'h7F;
    if (bus.sel && !bus.we) begin
      case (bus.addr)
        2'd0:    m_rdata = m_shadow;
        2'd1:    m_rdata = ctrl_word();
        2'd2:    m_rdata = {16'h0, m_frame, 4'h0, m_pending, 3'(idx)};
        default: m_rdata = 32'h0;
      endcase
    end
    was_en = m_en;
    if (bus.sel && bus.we && bus.addr == 2'd0) begin
      m_shadow  = bus.wdata;
      m_pending = 1'b1;
    end
    if (bus.sel && bus.we && bus.addr == 2'd1) begin
      m_en = bus.wdata[0]; m_lzb = bus.wdata[1]; m_bright = bus.wdata[7:4];
      m_mask = bus.wdata[15:8];
`ifdef SEVSEG_BLINK_EN
      m_blink = bus.wdata[23:16];
`endif
    end
    if (!was_en) begin
      m_tick = 0; m_active = m_shadow; m_pending = 1'b0;
    end else if (m_tick == FRAME - 1) begin
      m_tick = 0; m_active = m_shadow; m_pending = 1'b0; m_frame = m_frame + 8'd1;
    end else begin
      m_tick++;
    end
  endtask

  // One clock with the given bus inputs; model and DUT compared after the edge.
  task automatic cycle(input logic s, input logic w, input logic [1:0] a, input logic [31:0] d);
    bus.sel = s; bus.we = w; bus.addr = a; bus.wdata = d;
    @(posedge clk);
    model_step();
    #1;
    chk("an", 32'(an), 32'(m_an));
    chk("a_to_g", 32'(a_to_g), 32'(m_seg));
    chk("rdata", bus.rdata, m_rdata);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [1:0] a);
    cycle(1'b1, 1'b0, a, 32'h0);
  endtask

  // Idle until the model sits on the last cycle of a frame (bounded).
  task automatic to_boundary();
    for (int k = 0; k < FRAME && m_tick != FRAME - 1; k++) idle();
  endtask

  // Run one frame and tally lit cycles and shown segments per digit.
  task automatic run_frame();
    for (int d = 0; d < 8; d++) begin cnt_low[d] = 0; seg_seen[d] = 7'h7F; end
    for (int k = 0; k < FRAME; k++) begin
      idle();
      for (int d = 0; d < 8; d++) begin
        if (an == ~(8'(1) << d)) begin
          cnt_low[d]++;
          seg_seen[d] = a_to_g;
        end
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [10];
  int   lows;

  initial begin
    vecs[0] = '{1'b0, 2'd1, 32'h0,        1'b1, 32'h0000FFF1};
    vecs[1] = '{1'b0, 2'd0, 32'h0,        1'b1, 32'h00000000};
    vecs[2] = '{1'b1, 2'd1, 32'hFFFFA53F, 1'b0, 32'h0};
`ifdef SEVSEG_BLINK_EN
    vecs[3] = '{1'b0, 2'd1, 32'h0,        1'b1, 32'h00FFA533};
`else
    vecs[3] = '{1'b0, 2'd1, 32'h0,        1'b1, 32'h0000A533};
`endif
    vecs[4] = '{1'b1, 2'd2, 32'hFFFFFFFF, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 2'd3, 32'hFFFFFFFF, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 2'd3, 32'h0,        1'b1, 32'h00000000};
    vecs[7] = '{1'b1, 2'd0, 32'h12345678, 1'b0, 32'h0};
    vecs[8] = '{1'b0, 2'd0, 32'h0,        1'b1, 32'h12345678};
    vecs[9] = '{1'b1, 2'd1, 32'h0000FFF1, 1'b0, 32'h0};

    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = 32'h0;
    rst = 1'b1;
    idle(); idle();
    chk("reset_an", 32'(an), 32'hFF);
    chk("reset_seg", 32'(a_to_g), 32'h7F);
    chk("reset_rdata", bus.rdata, 32'h0);
    rst = 1'b0;

    // Plain scan of zeros: each digit 31 lit cycles per 32-cycle slot
    run_frame();
    chk("scan_d0_lit", 32'(cnt_low[0]), 32'd31);
    chk("scan_d7_lit", 32'(cnt_low[7]), 32'd31);
    chk("scan_d0_seg", 32'(seg_seen[0]), 32'h01);
    chk("scan_d4_seg", 32'(seg_seen[4]), 32'h01);

    // Register table
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].exp_rd);
    end
    to_boundary(); idle();

    // Mid-frame DATA write stays pending until the frame boundary
    for (int k = 0; k < 40; k++) idle();
    wr(2'd0, 32'h89ABCDEF);
    rd(2'd2);
    chk("pending_set", 32'(bus.rdata[3]), 32'd1);
    to_boundary(); idle();
    rd(2'd2);
    chk("pending_clr", 32'(bus.rdata[3]), 32'd0);
    run_frame();
    chk("data_d0_F", 32'(seg_seen[0]), 32'h38);
    chk("data_d7_8", 32'(seg_seen[7]), 32'h00);
    chk("data_d5_A", 32'(seg_seen[5]), 32'h08);

    // Brightness 3: 7 lit cycles per slot
    wr(2'd1, 32'h0000FF31);
    to_boundary();
    run_frame();
    lows = 0;
    for (int d = 0; d < 8; d++) lows += cnt_low[d];
    chk("bright3_d0", 32'(cnt_low[0]), 32'd7);
    chk("bright3_total", 32'(lows), 32'd56);

    // Leading-zero blanking
    wr(2'd0, 32'h00000105);
    wr(2'd1, 32'h0000FFF3);
    to_boundary(); idle();
    run_frame();
    lows = 0;
    for (int d = 3; d < 8; d++) lows += cnt_low[d];
    chk("lzb_hi_dark", 32'(lows), 32'd0);
    chk("lzb_d0_lit", 32'(cnt_low[0]), 32'd31);
    chk("lzb_d1_seg", 32'(seg_seen[1]), 32'h01);
    chk("lzb_d2_seg", 32'(seg_seen[2]), 32'h4F);
    wr(2'd1, 32'h0000FFF1);
    run_frame();
    chk("nolzb_d7_lit", 32'(cnt_low[7]), 32'd31);
    chk("nolzb_d7_seg", 32'(seg_seen[7]), 32'h01);

    // Disable mid-scan, then re-enable
    for (int k = 0; k < 77; k++) idle();
    wr(2'd1, 32'h0000FFF0);
    idle();
    chk("dis_an", 32'(an), 32'hFF);
    chk("dis_seg", 32'(a_to_g), 32'h7F);
    rd(2'd2);
    chk("dis_idx", 32'(bus.rdata[2:0]), 32'd0);
    wr(2'd1, 32'h0000FFF1);
    idle();
    chk("reen_ghost", 32'(an), 32'hFF);
    idle();
    chk("reen_d0", 32'(an), 32'hFE);

    // DATA write landing in the boundary cycle
    to_boundary();
    wr(2'd0, 32'h0000ABCD);
    rd(2'd2);
    chk("bnd_pending", 32'(bus.rdata[3]), 32'd0);
    run_frame();
    chk("bnd_d0_D", 32'(seg_seen[0]), 32'h42);
    chk("bnd_d3_A", 32'(seg_seen[3]), 32'h08);

    // Reset mid-frame
    wr(2'd1, 32'h0003A5C3);
    for (int k = 0; k < 50; k++) idle();
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("rst_an", 32'(an), 32'hFF);
    rd(2'd1);
    chk("rst_ctrl", bus.rdata, 32'h0000FFF1);
    rd(2'd0);
    chk("rst_data", bus.rdata, 32'h0);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      int r;
      logic [31:0] d;
      r = int'($urandom_range(0, 99));
      d = $urandom;
      if (k % 997 == 500) begin
        rst = 1'b1; idle(); rst = 1'b0;
      end else if (r < 60) begin
        idle();
      end else if (r < 75) begin
        rd(2'($urandom_range(0, 3)));
      end else if (r < 85) begin
        wr(2'd0, ($urandom_range(0, 1) == 1) ? (d >> (4 * $urandom_range(0, 7))) : d);
      end else if (r < 95) begin
        d[0] = ($urandom_range(0, 7) != 0);
        wr(2'd1, d);
      end else begin
        wr(2'($urandom_range(2, 3)), d);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
